// File: rtl/smart_home_cmd_parser_if.sv
// smart_home_cmd_parser_if
//   Byte-stream and actuator bundle between a UART byte receiver and the
//   smart-home command parser.
//   master : byte source side (drives rx_data/rx_valid, observes the outputs)
//   slave  : parser side (consumes rx_data/rx_valid, drives actuators/strobes)
//   Signals: rx_data[7:0], rx_valid, lights[NUM_LIGHTS-1:0], fan_speed[1:0],
//            setpoint[7:0], door_lock, frame_busy, cmd_ok, cmd_err,
//            err_code[1:0]
interface smart_home_cmd_parser_if #(
  parameter int unsigned NUM_LIGHTS = 4
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic [NUM_LIGHTS-1:0] lights;
  logic [1:0]            fan_speed;
  logic [7:0]            setpoint;
  logic                  door_lock;
  logic                  frame_busy;
  logic                  cmd_ok;
  logic                  cmd_err;
  logic [1:0]            err_code;

  modport master (
    output rx_data, rx_valid,
    input  lights, fan_speed, setpoint, door_lock,
           frame_busy, cmd_ok, cmd_err, err_code
  );

  modport slave (
    input  rx_data, rx_valid,
    output lights, fan_speed, setpoint, door_lock,
           frame_busy, cmd_ok, cmd_err, err_code
  );
endinterface

// File: rtl/smart_home_cmd_parser.sv
// smart_home_cmd_parser
//   Assembles 4-byte frames (SYNC, CMD, ARG, CHK) from a UART receiver,
//   validates them and drives the home actuator registers. Every completed
//   or aborted frame yields a one-cycle cmd_ok or cmd_err pulse.
//   Ports:
//     clk    - system clock
//     rst_n  - asynchronous active-low reset
//     bus    - slave modport: rx_data/rx_valid in; lights, fan_speed,
//              setpoint, door_lock, frame_busy, cmd_ok, cmd_err, err_code out
module smart_home_cmd_parser #(
  parameter int unsigned NUM_LIGHTS       = 4,
  parameter logic [7:0]  SYNC_BYTE        = 8'hAA,
  parameter int unsigned TIMEOUT_CYCLES   = 1000000,
  parameter logic [7:0]  SETPOINT_MIN     = 8'd10,
  parameter logic [7:0]  SETPOINT_MAX     = 8'd35,
  parameter logic [7:0]  SETPOINT_DEFAULT = 8'd22
) (
  input logic                     clk,
  input logic                     rst_n,
  smart_home_cmd_parser_if.slave  bus
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_ARG, S_CHK} state_e;

  state_e                state_q, state_d;
  logic                  rx_valid_q;
  logic [7:0]            cmd_q, cmd_d;
  logic [7:0]            arg_q, arg_d;
  logic [CW-1:0]         tmo_q, tmo_d;
  logic [NUM_LIGHTS-1:0] lights_q, lights_d;
  logic [1:0]            fan_q, fan_d;
  logic [7:0]            setpoint_q, setpoint_d;
  logic                  door_q, door_d;
  logic                  busy_q, busy_d;
  logic                  ok_q, ok_d;
  logic                  err_q, err_d;
  logic [1:0]            code_q, code_d;
  logic                  accept;
  logic                  bad_arg;

  // One byte per rising edge of the level-style rx_valid.
  assign accept = bus.rx_valid & ~rx_valid_q;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    arg_d      = arg_q;
    tmo_d      = tmo_q;
    lights_d   = lights_q;
    fan_d      = fan_q;
    setpoint_d = setpoint_q;
    door_d     = door_q;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    code_d     = code_q;
    bad_arg    = 1'b0;

    if (state_q == S_IDLE) begin
      tmo_d = '0;
      if (accept && bus.rx_data == SYNC_BYTE) state_d = S_CMD;
    end else if (accept) begin
      // An accept in the expiry cycle wins over the timeout.
      tmo_d = '0;
      case (state_q)
        S_CMD: begin
          cmd_d   = bus.rx_data;
          state_d = S_ARG;
        end
        S_ARG: begin
          arg_d   = bus.rx_data;
          state_d = S_CHK;
        end
        default: begin
          state_d = S_IDLE;
          if (bus.rx_data != (cmd_q ^ arg_q)) begin
            err_d  = 1'b1;
            code_d = 2'b10;
          end else begin
            case (cmd_q)
              8'h01: begin
                if (32'(arg_q[7:4]) < NUM_LIGHTS) begin
                  for (int unsigned i = 0; i < NUM_LIGHTS; i++)
                    if (i == 32'(arg_q[7:4])) lights_d[i] = arg_q[0];
                end else bad_arg = 1'b1;
              end
              8'h02: begin
                if (arg_q <= 8'd3) fan_d = arg_q[1:0];
                else bad_arg = 1'b1;
              end
              8'h03: begin
                if (arg_q >= SETPOINT_MIN && arg_q <= SETPOINT_MAX) setpoint_d = arg_q;
                else bad_arg = 1'b1;
              end
              8'h04: begin
                if (arg_q <= 8'd1) door_d = arg_q[0];
                else bad_arg = 1'b1;
              end
              default: bad_arg = 1'b1;
            endcase
            if (bad_arg) begin
              err_d  = 1'b1;
              code_d = 2'b11;
            end else begin
              ok_d = 1'b1;
            end
          end
        end
      endcase
    end else if (tmo_q == TMO_LAST) begin
      state_d = S_IDLE;
      tmo_d   = '0;
      err_d   = 1'b1;
      code_d  = 2'b01;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rx_valid_q <= 1'b0;
      cmd_q      <= '0;
      arg_q      <= '0;
      tmo_q      <= '0;
      lights_q   <= '0;
      fan_q      <= '0;
      setpoint_q <= SETPOINT_DEFAULT;
      door_q     <= 1'b1;
      busy_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= '0;
    end else begin
      state_q    <= state_d;
      rx_valid_q <= bus.rx_valid;
      cmd_q      <= cmd_d;
      arg_q      <= arg_d;
      tmo_q      <= tmo_d;
      lights_q   <= lights_d;
      fan_q      <= fan_d;
      setpoint_q <= setpoint_d;
      door_q     <= door_d;
      busy_q     <= busy_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

  assign bus.lights     = lights_q;
  assign bus.fan_speed  = fan_q;
  assign bus.setpoint   = setpoint_q;
  assign bus.door_lock  = door_q;
  assign bus.frame_busy = busy_q;
  assign bus.cmd_ok     = ok_q;
  assign bus.cmd_err    = err_q;
  assign bus.err_code   = code_q;

endmodule
